// File: rtl/mine_place_ctrl.sv
// Mine placement sequencer.
// Clears the mine bitmap, then fills it with exactly MINE_NUM distinct mines
// drawn from a free-running random {x,y} sample. Samples that are off the map,
// land on the protected safe cell or hit an existing mine are rejected. After
// MAX_TRIES consecutive rejects a linear scan from the last rejected cell
// places the next mine, so completion time stays bounded. The finished bitmap
// is held stable for the neighbour-count datapath until the next start.
module mine_place_ctrl #(
    parameter int MAP_WIDTH  = 8,
    parameter int MAP_HEIGHT = 8,
    parameter int COORD_W    = 3,
    parameter int MINE_NUM   = 10,
    parameter int MAX_TRIES  = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start_i,
    input  logic [COORD_W-1:0]                          safe_x_i,
    input  logic [COORD_W-1:0]                          safe_y_i,
    input  logic [2*COORD_W-1:0]                        rand_i,
    output logic                                        busy_o,
    output logic                                        done_o,
    output logic                                        map_valid_o,
    output logic [MAP_WIDTH*MAP_HEIGHT-1:0]             mine_map_o,
    output logic [$clog2(MAP_WIDTH*MAP_HEIGHT+1)-1:0]   mine_cnt_o
);

    localparam int CELLS  = MAP_WIDTH * MAP_HEIGHT;
    localparam int IDX_W  = $clog2(CELLS);
    localparam int CNT_W  = $clog2(CELLS + 1);
    localparam int REJ_W  = $clog2(MAX_TRIES + 1);
    localparam int WIDE_W = 2 * COORD_W + 1;

    localparam logic [COORD_W:0]  X_LIM     = (COORD_W + 1)'(MAP_WIDTH);
    localparam logic [COORD_W:0]  Y_LIM     = (COORD_W + 1)'(MAP_HEIGHT);
    localparam logic [IDX_W-1:0]  LAST_CELL = IDX_W'(CELLS - 1);
    localparam logic [CNT_W-1:0]  LAST_MINE = CNT_W'(MINE_NUM - 1);
    localparam logic [REJ_W-1:0]  LAST_TRY  = REJ_W'(MAX_TRIES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PLACE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [CELLS-1:0]   mine_map;
    logic [CNT_W-1:0]   mine_cnt;
    logic [REJ_W-1:0]   rej_cnt;
    logic [IDX_W-1:0]   scan_ptr;
    logic [IDX_W-1:0]   safe_idx;
    logic               safe_ok;
    logic               map_valid;

    logic [COORD_W-1:0] rand_x;
    logic [COORD_W-1:0] rand_y;
    logic [IDX_W-1:0]   rand_idx;
    logic               rand_in_map;
    logic               rand_reject;
    logic [IDX_W-1:0]   safe_in_idx;
    logic               safe_in_map;
    logic               scan_free;
    logic               place_en;
    logic [IDX_W-1:0]   place_idx;
    logic               last_mine;
    logic               enter_scan;

    // Linear cell index x + y*MAP_WIDTH, wide enough for any coordinate pair.
    function automatic logic [WIDE_W-1:0] lin_idx(input logic [COORD_W-1:0] cx,
                                                  input logic [COORD_W-1:0] cy);
        return WIDE_W'(cx) + WIDE_W'(cy) * WIDE_W'(MAP_WIDTH);
    endfunction

    // True when the coordinate pair addresses a real cell of the map.
    function automatic logic on_map(input logic [COORD_W-1:0] cx,
                                    input logic [COORD_W-1:0] cy);
        return ({1'b0, cx} < X_LIM) && ({1'b0, cy} < Y_LIM);
    endfunction

    // Decode the random sample and the safe-cell inputs into cell indices.
    always_comb begin
        rand_x      = rand_i[2*COORD_W-1:COORD_W];
        rand_y      = rand_i[COORD_W-1:0];
        rand_in_map = on_map(rand_x, rand_y);
        rand_idx    = IDX_W'(lin_idx(rand_x, rand_y) % WIDE_W'(CELLS));
        safe_in_map = on_map(safe_x_i, safe_y_i);
        safe_in_idx = IDX_W'(lin_idx(safe_x_i, safe_y_i) % WIDE_W'(CELLS));
    end

    // Acceptance tests for the random sample and for the current scan cell.
    always_comb begin
        rand_reject = !rand_in_map
                      || (safe_ok && (rand_idx == safe_idx))
                      || mine_map[rand_idx];
        scan_free   = !mine_map[scan_ptr] && !(safe_ok && (scan_ptr == safe_idx));
        last_mine   = (mine_cnt == LAST_MINE);
        enter_scan  = (state == S_PLACE) && rand_reject && (rej_cnt == LAST_TRY);
    end

    // Select which cell, if any, receives a mine this cycle (at most one).
    always_comb begin
        place_en  = 1'b0;
        place_idx = rand_idx;
        if ((state == S_PLACE) && !rand_reject) begin
            place_en  = 1'b1;
        end else if ((state == S_SCAN) && scan_free) begin
            place_en  = 1'b1;
            place_idx = scan_ptr;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                next_state = S_PLACE;
            end
            S_PLACE: begin
                if (place_en) begin
                    next_state = last_mine ? S_DONE : S_PLACE;
                end else if (enter_scan) begin
                    next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                if (place_en) begin
                    next_state = last_mine ? S_DONE : S_PLACE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy_o = (state == S_CLEAR) || (state == S_PLACE) || (state == S_SCAN);
        done_o = (state == S_DONE);
    end

    // Capture the safe cell once per run so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            safe_idx <= '0;
            safe_ok  <= 1'b0;
        end else if ((state == S_IDLE) && start_i) begin
            safe_idx <= safe_in_idx;
            safe_ok  <= safe_in_map;
        end
    end

    // Bitmap and mine counter: cleared in CLEAR, one bit set per placement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mine_map <= '0;
            mine_cnt <= '0;
        end else if (state == S_CLEAR) begin
            mine_map <= '0;
            mine_cnt <= '0;
        end else if (place_en) begin
            mine_map[place_idx] <= 1'b1;
            mine_cnt            <= mine_cnt + CNT_W'(1);
        end
    end

    // Consecutive-reject counter; any placement restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rej_cnt <= '0;
        end else if ((state == S_CLEAR) || place_en) begin
            rej_cnt <= '0;
        end else if (state == S_PLACE) begin
            rej_cnt <= rej_cnt + REJ_W'(1);
        end
    end

    // Scan pointer: seeded from the last rejected sample, then walks and wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_ptr <= '0;
        end else if (enter_scan) begin
            scan_ptr <= rand_idx;
        end else if ((state == S_SCAN) && !scan_free) begin
            scan_ptr <= (scan_ptr == LAST_CELL) ? '0 : scan_ptr + IDX_W'(1);
        end
    end

    // Map-valid flag: rises with the final placement, drops once a new run starts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            map_valid <= 1'b0;
        end else if ((state == S_IDLE) && start_i) begin
            map_valid <= 1'b0;
        end else if (place_en && last_mine) begin
            map_valid <= 1'b1;
        end
    end

    // Drive the bitmap interface.
    always_comb begin
        mine_map_o  = mine_map;
        mine_cnt_o  = mine_cnt;
        map_valid_o = map_valid;
    end

    // The counter never overshoots and always matches the bitmap population.
    cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        int'(mine_cnt) <= MINE_NUM);
    cnt_matches_map: assert property (@(posedge clk) disable iff (!rst_n)
        $countones(mine_map) == int'(mine_cnt));

endmodule

// File: tb/tb_mine_place_ctrl.sv
// Scoreboard bench for mine_place_ctrl: stimulus pushes the expected finished
// map, count and start-to-done latency; monitors pop them on every done pulse.
// Instance a uses MINE_NUM=10, instance b uses MINE_NUM=63 (near-full map).
module tb_mine_place_ctrl;

    typedef struct {
        logic [63:0] map;
        int          cnt;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start_a;
    logic [2:0]  safe_x_a;
    logic [2:0]  safe_y_a;
    logic [5:0]  rand_a;
    logic        busy_a;
    logic        done_a;
    logic        valid_a;
    logic [63:0] map_a;
    logic [6:0]  cnt_a;

    logic        start_b;
    logic [2:0]  safe_x_b;
    logic [2:0]  safe_y_b;
    logic [5:0]  rand_b;
    logic        busy_b;
    logic        done_b;
    logic        valid_b;
    logic [63:0] map_b;
    logic [6:0]  cnt_b;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   start_cyc_a = 0;
    int   start_cyc_b = 0;
    bit   done_seen_b = 1'b0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   seq[$];

    mine_place_ctrl #(.MINE_NUM(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a),
        .safe_x_i(safe_x_a), .safe_y_i(safe_y_a), .rand_i(rand_a),
        .busy_o(busy_a), .done_o(done_a), .map_valid_o(valid_a),
        .mine_map_o(map_a), .mine_cnt_o(cnt_a)
    );

    mine_place_ctrl #(.MINE_NUM(63)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b),
        .safe_x_i(safe_x_b), .safe_y_i(safe_y_b), .rand_i(rand_b),
        .busy_o(busy_b), .done_o(done_b), .map_valid_o(valid_b),
        .mine_map_o(map_b), .mine_cnt_o(cnt_b)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts every check and reports any difference.
    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Random sample {x,y} for linear cell index idx on the 8x8 map.
    function automatic logic [5:0] mk(input int idx);
        logic [2:0] xx;
        logic [2:0] yy;
        xx = idx[2:0];
        yy = idx[5:3];
        return {xx, yy};
    endfunction

    // Monitor for instance a: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done_a) begin
            if (qa.size() == 0) begin
                check_output("unexpected_done_a", 64'd1, 64'd0);
            end else begin
                ea = qa.pop_front();
                check_output("a_map", map_a, ea.map);
                check_output("a_cnt", 64'(cnt_a), 64'(ea.cnt));
                check_output("a_latency", 64'(cyc - start_cyc_a), 64'(ea.lat));
                check_output("a_valid_at_done", 64'(valid_a), 64'd1);
            end
        end
    end

    // Monitor for instance b.
    always @(negedge clk) begin
        if (rst_n && done_b) begin
            if (qb.size() == 0) begin
                check_output("unexpected_done_b", 64'd1, 64'd0);
            end else begin
                eb = qb.pop_front();
                check_output("b_map", map_b, eb.map);
                check_output("b_cnt", 64'(cnt_b), 64'(eb.cnt));
                check_output("b_latency", 64'(cyc - start_cyc_b), 64'(eb.lat));
                check_output("b_valid_at_done", 64'(valid_b), 64'd1);
            end
            done_seen_b = 1'b1;
        end
    end

    // One run on instance a: start at offset 0, safe cell changed at offset 1,
    // optional extra start pulse at offset extra, seq[k] fed at offset k+2.
    task automatic apply_stimulus(input logic [2:0] sx, input logic [2:0] sy,
                                  input logic [2:0] ax, input logic [2:0] ay,
                                  input int extra, input logic [63:0] emap,
                                  input int ecnt, input int elat);
        exp_t e;
        int   si;
        int   total;
        e.map = emap;
        e.cnt = ecnt;
        e.lat = elat;
        qa.push_back(e);
        total = seq.size() + 14;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start_cyc_a = cyc;
                safe_x_a    = sx;
                safe_y_a    = sy;
            end
            if (k == 1) begin
                safe_x_a = ax;
                safe_y_a = ay;
                check_output("valid_drops_after_start", 64'(valid_a), 64'd0);
            end
            start_a = (k == 0) || (k == extra);
            si = k - 2;
            if (si < 0) si = 0;
            if (si > seq.size() - 1) si = seq.size() - 1;
            rand_a = mk(seq[si]);
        end
        @(negedge clk);
        start_a = 1'b0;
        check_output("idle_after_run", 64'(busy_a), 64'd0);
        check_output("valid_held", 64'(valid_a), 64'd1);
        check_output("cnt_held", 64'(cnt_a), 64'(ecnt));
        check_output("map_held", map_a, emap);
    endtask

    initial begin
        rst_n    = 1'b0;
        start_a  = 1'b0;
        safe_x_a = 3'd0;
        safe_y_a = 3'd0;
        rand_a   = 6'd0;
        start_b  = 1'b0;
        safe_x_b = 3'd7;
        safe_y_b = 3'd7;
        rand_b   = 6'd0;

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        check_output("rst_busy_a", 64'(busy_a), 64'd0);
        check_output("rst_done_a", 64'(done_a), 64'd0);
        check_output("rst_valid_a", 64'(valid_a), 64'd0);
        check_output("rst_map_a", map_a, 64'd0);
        check_output("rst_cnt_a", 64'(cnt_a), 64'd0);
        check_output("rst_busy_b", 64'(busy_b), 64'd0);
        check_output("rst_map_b", map_b, 64'd0);
        check_output("rst_cnt_b", 64'(cnt_b), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ten distinct cells, safe moved to (5,0) after start (must be ignored),
        // extra start in the DONE cycle (must be ignored).
        $display("[TB] case 1: ten distinct cells");
        seq = '{5, 10, 15, 20, 25, 30, 35, 40, 45, 50};
        apply_stimulus(3'd0, 3'd0, 3'd5, 3'd0, 12, 64'h0004_2108_4210_8420, 10, 12);

        // Cell 9 repeated three times: three extra cycles.
        $display("[TB] case 2: duplicate rejection");
        seq = '{9, 9, 9, 9, 1, 2, 3, 4, 5, 6, 7, 8, 10};
        apply_stimulus(3'd0, 3'd0, 3'd0, 3'd0, -1, 64'h0000_0000_0000_07FE, 10, 15);

        // Stuck on safe cell (3,2): scan from 19 skips it and places at 20.
        $display("[TB] case 3: scan fallback");
        seq = {};
        repeat (18) seq.push_back(19);
        for (int i = 1; i <= 9; i++) seq.push_back(i);
        apply_stimulus(3'd3, 3'd2, 3'd3, 3'd2, -1, 64'h0000_0000_0010_03FE, 10, 29);

        // Start pulse after four mines is ignored.
        $display("[TB] case 4: start during placement");
        seq = '{5, 10, 15, 20, 25, 30, 35, 40, 45, 50};
        apply_stimulus(3'd0, 3'd0, 3'd0, 3'd0, 6, 64'h0004_2108_4210_8420, 10, 12);

        // Reset in the first SCAN cycle aborts the run.
        $display("[TB] case 5: reset during scan");
        @(negedge clk);
        start_a  = 1'b1;
        safe_x_a = 3'd3;
        safe_y_a = 3'd2;
        rand_a   = mk(1);
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (k == 2) rand_a = mk(1);
            else if (k == 3) rand_a = mk(2);
            else if (k == 4) rand_a = mk(3);
            else rand_a = mk(19);
        end
        check_output("scan_busy", 64'(busy_a), 64'd1);
        check_output("scan_cnt", 64'(cnt_a), 64'd3);
        check_output("scan_map", map_a, 64'h0000_0000_0000_000E);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("abort_busy", 64'(busy_a), 64'd0);
        check_output("abort_done", 64'(done_a), 64'd0);
        check_output("abort_valid", 64'(valid_a), 64'd0);
        check_output("abort_map", map_a, 64'd0);
        check_output("abort_cnt", 64'(cnt_a), 64'd0);
        rst_n = 1'b1;

        $display("[TB] case 5b: normal run after abort");
        seq = '{9, 9, 9, 9, 1, 2, 3, 4, 5, 6, 7, 8, 10};
        apply_stimulus(3'd0, 3'd0, 3'd0, 3'd0, -1, 64'h0000_0000_0000_07FE, 10, 15);

        // 63 mines, safe (7,7), constant sample at cell 0: every mine after the
        // first needs 16 rejects plus a k+1 cycle scan, 3010 cycles in total.
        $display("[TB] case 6: near-full map via scan");
        @(negedge clk);
        eb.map = 64'h7FFF_FFFF_FFFF_FFFF;
        eb.cnt = 63;
        eb.lat = 3010;
        qb.push_back(eb);
        safe_x_b    = 3'd7;
        safe_y_b    = 3'd7;
        rand_b      = 6'd0;
        start_b     = 1'b1;
        start_cyc_b = cyc;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (done_seen_b) break;
        end
        check_output("b_finished", 64'(done_seen_b), 64'd1);
        @(negedge clk);
        check_output("b_idle", 64'(busy_b), 64'd0);
        check_output("b_valid_held", 64'(valid_b), 64'd1);

        check_output("queues_drained", 64'(qa.size() + qb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
